// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Build option: define CLKDIV_DUTY_EN to enable a programmable high time.
package clkdiv_pkg;

  localparam int unsigned CLKDIV_MIN_DIV = 2;

  // Divisors below the minimum are promoted to the minimum.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < CLKDIV_MIN_DIV) ? 32'(CLKDIV_MIN_DIV) : d;
  endfunction

  // Default high time: the extra cycle of an odd divisor goes to the high phase.
  function automatic logic [31:0] default_high(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

  // Programmable high time is kept within 1..n-1 so both phases exist.
  function automatic logic [31:0] clamp_high(input logic [31:0] h, input logic [31:0] n);
    if (h < 32'd1)
      return 32'd1;
    else if (h > n - 32'd1)
      return n - 32'd1;
    else
      return h;
  endfunction

endpackage

// File: rtl/clkdiv_phase_ctr.sv
// Phase counter for clkdiv_prog.
// Ports: inClk/reset (async, active-high), enable advances the phase,
// div is the active divisor; wrap_c flags the last phase of the period,
// cnt_next_c is the phase the counter moves to on the next enabled edge.
module clkdiv_phase_ctr #(
  parameter int unsigned bitSize = 16,
  parameter int unsigned RST_CNT = 3
) (
  input  logic               inClk,
  input  logic               reset,
  input  logic               enable,
  input  logic [bitSize-1:0] div,
  output logic               wrap_c,
  output logic [bitSize-1:0] cnt_next_c
);

  logic [bitSize-1:0] cnt_q;
  logic [bitSize-1:0] cnt_d;

  // Phase stays in 0..div-1; div only changes on a wrap, when cnt returns to 0.
  always_comb begin
    wrap_c     = (cnt_q == div - bitSize'(1));
    cnt_next_c = wrap_c ? '0 : cnt_q + bitSize'(1);
    cnt_d      = enable ? cnt_next_c : cnt_q;
  end

  always_ff @(posedge inClk or posedge reset) begin
    if (reset) cnt_q <= bitSize'(RST_CNT);
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clkdiv_prog.sv
// Runtime-programmable integer clock divider (N >= 2, odd N allowed).
// Ports: inClk, reset (async, active-high), enable (freeze when low),
// divIn/divLoad (request a new divisor, applied at the next period boundary),
// divPending, outClk (registered divided clock), riseStb/fallStb (edge strobes).
// Build option CLKDIV_DUTY_EN adds highIn: programmable high time, loaded with divIn.
module clkdiv_prog #(
  parameter int unsigned bitSize     = 16,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic               inClk,
  input  logic               reset,
  input  logic               enable,
  input  logic [bitSize-1:0] divIn,
`ifdef CLKDIV_DUTY_EN
  input  logic [bitSize-1:0] highIn,
`endif
  input  logic               divLoad,
  output logic               divPending,
  output logic               outClk,
  output logic               riseStb,
  output logic               fallStb
);
  import clkdiv_pkg::*;

  logic [bitSize-1:0] div_q, div_d;
  logic [bitSize-1:0] pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic               out_clk_q, out_clk_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               wrap_c, apply_c;
  logic [bitSize-1:0] cnt_next_c, div_in_c, high_c;

  clkdiv_phase_ctr #(
    .bitSize (bitSize),
    .RST_CNT (DEFAULT_DIV - 1)
  ) u_phase_ctr (
    .inClk      (inClk),
    .reset      (reset),
    .enable     (enable),
    .div        (div_q),
    .wrap_c     (wrap_c),
    .cnt_next_c (cnt_next_c)
  );

`ifdef CLKDIV_DUTY_EN
  logic [bitSize-1:0] high_q, high_d;
  logic [bitSize-1:0] pend_high_q, pend_high_d;
  logic [bitSize-1:0] high_in_c;

  // High time is clamped against the clamped divisor it travels with.
  always_comb begin
    high_in_c   = bitSize'(clamp_high(32'(highIn), 32'(div_in_c)));
    high_c      = high_q;
    high_d      = high_q;
    pend_high_d = pend_high_q;
    if (apply_c) begin
      if (divLoad)         high_d = high_in_c;
      else if (pend_vld_q) high_d = pend_high_q;
    end else if (divLoad) begin
      pend_high_d = high_in_c;
    end
  end

  always_ff @(posedge inClk or posedge reset) begin
    if (reset) begin
      high_q      <= bitSize'(DEFAULT_DIV / 2);
      pend_high_q <= '0;
    end else begin
      high_q      <= high_d;
      pend_high_q <= pend_high_d;
    end
  end
`else
  assign high_c = bitSize'(default_high(32'(div_q)));
`endif

  // Divisor reload: held in pend until an enabled wrap; a load on the wrap itself bypasses pend.
  always_comb begin
    div_in_c   = bitSize'(clamp_div(32'(divIn)));
    apply_c    = enable & wrap_c;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (apply_c) begin
      pend_vld_d = 1'b0;
      if (divLoad)         div_d = div_in_c;
      else if (pend_vld_q) div_d = pend_q;
    end else if (divLoad) begin
      pend_d     = div_in_c;
      pend_vld_d = 1'b1;
    end
  end

  // Output phase decode; on a wrap cnt_next is 0 so the old high value is still correct.
  always_comb begin
    out_clk_d = out_clk_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (enable) begin
      out_clk_d = (cnt_next_c < high_c);
      rise_d    = (cnt_next_c == '0);
      fall_d    = (cnt_next_c == high_c);
    end
  end

  always_ff @(posedge inClk or posedge reset) begin
    if (reset) begin
      div_q      <= bitSize'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      out_clk_q  <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      out_clk_q  <= out_clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign divPending = pend_vld_q;
  assign outClk     = out_clk_q;
  assign riseStb    = rise_q;
  assign fallStb    = fall_q;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Scoreboard bench for clkdiv_prog: the driver pushes expected outputs from a
// period-waveform model; the monitor pops and compares after every posedge.
module tb_clkdiv_prog;

  localparam int unsigned W   = 16;
  localparam int unsigned DEF = 4;

  logic         inClk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] divIn;
  logic         divLoad;
  logic         divPending, outClk, riseStb, fallStb;
`ifdef CLKDIV_DUTY_EN
  logic [W-1:0] highIn;
  int           forced_hin = -1;
`endif

  clkdiv_prog #(.bitSize(W), .DEFAULT_DIV(DEF)) dut (
    .inClk      (inClk),
    .reset      (reset),
    .enable     (enable),
    .divIn      (divIn),
`ifdef CLKDIV_DUTY_EN
    .highIn     (highIn),
`endif
    .divLoad    (divLoad),
    .divPending (divPending),
    .outClk     (outClk),
    .riseStb    (riseStb),
    .fallStb    (fallStb)
  );

  always #5 inClk = ~inClk;

  typedef struct packed {
    logic out;
    logic rise;
    logic fall;
    logic pend;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: each period is a precomputed waveform consumed one bit per enabled cycle.
  exp_t m_wave[$];
  int   m_div, m_high, m_pend_div, m_pend_high;
  bit   m_pend, m_out;

  function automatic void model_reset();
    m_div  = DEF;
`ifdef CLKDIV_DUTY_EN
    m_high = DEF / 2;
`else
    m_high = DEF - DEF / 2;
`endif
    m_pend = 1'b0;
    m_out  = 1'b0;
    m_wave.delete();
  endfunction

  function automatic void start_period(input int n, input int h);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e      = '0;
      e.out  = (i < h);
      e.rise = (i == 0);
      e.fall = (i == h);
      m_wave.push_back(e);
    end
  endfunction

  function automatic exp_t model_step(input bit en, input bit ld, input int din, input int hin);
    exp_t e;
    int   nd, nh;
    e  = '0;
    nd = (din < 2) ? 2 : din;
`ifdef CLKDIV_DUTY_EN
    nh = (hin < 1) ? 1 : (hin > nd - 1) ? nd - 1 : hin;
`else
    nh = nd - nd / 2 + 0 * hin;
`endif
    if (en && m_wave.size() == 0) begin
      if (ld) begin
        m_div = nd; m_high = nh;
      end else if (m_pend) begin
        m_div = m_pend_div; m_high = m_pend_high;
      end
      m_pend = 1'b0;
      start_period(m_div, m_high);
    end else if (ld) begin
      m_pend = 1'b1; m_pend_div = nd; m_pend_high = nh;
    end
    if (en) begin
      e     = m_wave.pop_front();
      m_out = e.out;
    end
    e.out  = m_out;
    e.pend = m_pend;
    return e;
  endfunction

  task automatic step(input bit rst, input bit en, input bit ld, input int din);
    int hin;
    hin = 0;
    @(negedge inClk);
    reset   = rst;
    enable  = en;
    divLoad = ld;
    divIn   = W'(din);
`ifdef CLKDIV_DUTY_EN
    hin    = (forced_hin >= 0) ? forced_hin : int'($urandom_range(0, 12));
    highIn = W'(hin);
`endif
    if (rst) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      exp_q.push_back(model_step(en, ld, din, hin));
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a fresh output set after every posedge.
  always @(posedge inClk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("outClk",     outClk,     e.out);
      chk("riseStb",    riseStb,    e.rise);
      chk("fallStb",    fallStb,    e.fall);
      chk("divPending", divPending, e.pend);
    end
  end

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic load(input int d);
    step(1'b0, 1'b1, 1'b1, d);
  endtask

  initial begin
    bit found;
    reset = 1'b1; enable = 1'b1; divLoad = 1'b0; divIn = '0;
`ifdef CLKDIV_DUTY_EN
    highIn = '0;
`endif
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0);

    // Default divide-by-4 from reset release.
    run(13);
    // Mid-period load of 5.
    load(5);
    run(16);
    // Clamped divisors and an odd divisor.
    load(0); run(9);
    load(1); run(9);
    load(3); run(10);
    load(4); run(6);

    // Freeze for 7 cycles in the high phase, one high cycle still to go.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_wave.size() == m_div - 1) found = 1'b1;
      else run(1);
    end
    chk("freeze_point_found", found, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 0);
    run(10);

    // Two loads before the boundary: only the last one survives.
    run(1);
    load(6); load(9);
    run(22);

    // Load on the apply cycle takes effect directly.
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_wave.size() == 0) begin
        load(7);
        found = 1'b1;
      end else run(1);
    end
    chk("apply_cycle_found", found, 1'b1);
    run(16);

    // Async reset in the middle of a period with a load pending.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_wave.size() > 1) found = 1'b1;
      else run(1);
    end
    load(11);
    run(1);
    @(negedge inClk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_outClk", outClk, 1'b0);
    chk("async_rst_divPending", divPending, 1'b0);
    model_reset();
    exp_q.push_back('0);
    step(1'b1, 1'b1, 1'b0, 0);
    run(12);

`ifdef CLKDIV_DUTY_EN
    forced_hin = 3;  load(10); run(22);
    forced_hin = 0;  load(6);  run(14);
    forced_hin = -1;
`endif

    // Randomised traffic with occasional loads, freezes and resets.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 1)
        step(1'b1, 1'b1, 1'b0, 0);
      else
        step(1'b0, ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 8),
             int'($urandom_range(0, 12)));
    end

    @(negedge inClk);
    @(negedge inClk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
